// File: rtl/serial_pattern_gen.sv
// rtl/serial_pattern_gen.sv - serial bit-pattern generator; optional PRBS-7 source under SERIAL_PRBS7_EN
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic             prbs_sel,
  output logic             Signal,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] idx_q, idx_n;
  logic             loop_q, loop_n;
  logic             sig_n, valid_n, busy_n, done_n;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] last_idx;

  // Zero or oversize lengths collapse to the full pattern width at capture time.
  assign len_clamped = (length == '0 || length > LEN_MAX) ? LEN_MAX : length;
  assign last_idx    = len_q - LEN_W'(1);

  // Variable bit select done as a shift so the index width need not match $clog2(WIDTH).
  function automatic logic pat_bit(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    logic [WIDTH-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

`ifdef SERIAL_PRBS7_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  logic [6:0] prbs_q, prbs_n, prbs_step;
  logic       mode_q, mode_n;
  // x^7 + x^6 + 1; the bit shown each cycle is bit 6 of the current register value.
  assign prbs_step = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
`else
  logic unused_prbs_sel;
  assign unused_prbs_sel = prbs_sel;
`endif

  // Next-state and next-output logic; outputs default to the idle values.
  always_comb begin
    state_n = state_q;
    pat_n   = pat_q;
    len_n   = len_q;
    idx_n   = idx_q;
    loop_n  = loop_q;
    sig_n   = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
`ifdef SERIAL_PRBS7_EN
    prbs_n  = prbs_q;
    mode_n  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          pat_n = pattern;
          len_n = len_clamped;
        end
        if (start) begin
          state_n = RUN;
          idx_n   = '0;
          loop_n  = loop;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          sig_n   = load ? pattern[0] : pat_q[0];
`ifdef SERIAL_PRBS7_EN
          mode_n  = prbs_sel;
          prbs_n  = PRBS_SEED;
          if (prbs_sel) sig_n = PRBS_SEED[6];
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          if (idx_q == last_idx) begin
            idx_n = '0;
            if (!loop_q) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            idx_n = idx_q + LEN_W'(1);
          end
          if (state_n == RUN) begin
            valid_n = 1'b1;
            busy_n  = 1'b1;
            sig_n   = pat_bit(pat_q, idx_n);
`ifdef SERIAL_PRBS7_EN
            // The LFSR free-runs across wraps so the stream keeps its 127-bit period.
            prbs_n = prbs_step;
            if (mode_q) sig_n = prbs_step[6];
`endif
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= LEN_MAX;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      Signal  <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_PRBS7_EN
      prbs_q  <= PRBS_SEED;
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      idx_q   <= idx_n;
      loop_q  <= loop_n;
      Signal  <= sig_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SERIAL_PRBS7_EN
      prbs_q  <= prbs_n;
      mode_q  <= mode_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb/tb_serial_pattern_gen.sv - directed self-checking bench for serial_pattern_gen
module tb_serial_pattern_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] length = '0;
  logic             loop = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             prbs_sel = 1'b0;
  logic             Signal, valid, busy, done;

  int checks = 0;
  int errors = 0;

  // Hand-derived LSB-first streams.
  bit seq_one_shot [8]  = '{0, 1, 0, 0, 1, 1, 0, 1};
  bit seq_loop3    [12] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
  bit seq_a5       [8]  = '{1, 0, 1, 0, 0, 1, 0, 1};

  serial_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern), .length(length),
    .loop(loop), .start(start), .stop(stop), .prbs_sel(prbs_sel),
    .Signal(Signal), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {Signal, valid, busy, done});
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_release_idle got %b exp 0000", {Signal, valid, busy, done});
    end
  endtask

  task automatic test_one_shot;
    pattern = 8'b1011_0010; length = 4'd8; loop = 1'b0; load = 1'b1;
    tick;
    load = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({Signal, valid, busy, done} !== {seq_one_shot[i], 3'b110}) begin
        errors++; $display("FAIL one_shot_bit%0d got %b exp %b", i, {Signal, valid, busy, done}, {seq_one_shot[i], 3'b110});
      end
      if (i < 7) tick;
    end
    tick;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b0001) begin
      errors++; $display("FAIL one_shot_done got %b exp 0001", {Signal, valid, busy, done});
    end
    tick;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL one_shot_after_done got %b exp 0000", {Signal, valid, busy, done});
    end
  endtask

  task automatic test_loop;
    // load and start together: the new pattern must be used immediately.
    pattern = 8'b0000_0101; length = 4'd3; loop = 1'b1; load = 1'b1; start = 1'b1;
    tick;
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({Signal, valid, busy, done} !== {seq_loop3[i], 3'b110}) begin
        errors++; $display("FAIL loop_bit%0d got %b exp %b", i, {Signal, valid, busy, done}, {seq_loop3[i], 3'b110});
      end
      if (i < 11) tick;
    end
    // Last index of the pattern is showing: stop must win over the wrap.
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL loop_stop_at_wrap got %b exp 0000", {Signal, valid, busy, done});
    end
  endtask

  task automatic test_stop;
    // No reload: the stored 3-bit pattern must replay unchanged.
    loop = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({Signal, valid, busy, done} !== {seq_loop3[i], 3'b110}) begin
        errors++; $display("FAIL stop_run_bit%0d got %b exp %b", i, {Signal, valid, busy, done}, {seq_loop3[i], 3'b110});
      end
      if (i < 3) tick;
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({Signal, valid, busy, done} !== 4'b0000) begin
        errors++; $display("FAIL stop_idle%0d got %b exp 0000", i, {Signal, valid, busy, done});
      end
      tick;
    end
  endtask

  task automatic test_len_clamp;
    logic [LEN_W-1:0] lens [2];
    int cnt;
    bit got_done;
    lens[0] = 4'd0;
    lens[1] = 4'd12;
    for (int k = 0; k < 2; k++) begin
      pattern = 8'hA5; length = lens[k]; loop = 1'b0; load = 1'b1;
      tick;
      load = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      cnt = 0; got_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (valid) begin
          if (cnt < 8) begin
            checks++;
            if (Signal !== seq_a5[cnt]) begin
              errors++; $display("FAIL clamp_len%0d_bit%0d got %b exp %b", lens[k], cnt, Signal, seq_a5[cnt]);
            end
          end
          cnt++;
        end
        if (done) begin
          got_done = 1'b1;
          break;
        end
        tick;
      end
      checks++;
      if (cnt !== 8) begin
        errors++; $display("FAIL clamp_len%0d_count got %0d exp 8", lens[k], cnt);
      end
      checks++;
      if (got_done !== 1'b1) begin
        errors++; $display("FAIL clamp_len%0d_done got %b exp 1", lens[k], got_done);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    bit got_done;
    pattern = 8'hFF; length = 4'd8; loop = 1'b0; load = 1'b1; start = 1'b1;
    tick;
    load = 1'b0; start = 1'b0;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b1110) begin
      errors++; $display("FAIL mid_bit0 got %b exp 1110", {Signal, valid, busy, done});
    end
    // start and load while running must not disturb the stream.
    pattern = 8'h00; length = 4'd3; load = 1'b1; start = 1'b1;
    tick;
    load = 1'b0; start = 1'b0;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b1110) begin
      errors++; $display("FAIL mid_ignore_load_start got %b exp 1110", {Signal, valid, busy, done});
    end
    tick;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b1110) begin
      errors++; $display("FAIL mid_bit2 got %b exp 1110", {Signal, valid, busy, done});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({Signal, valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL mid_async_reset got %b exp 0000", {Signal, valid, busy, done});
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({Signal, valid, busy, done} !== 4'b0000) begin
        errors++; $display("FAIL mid_post_reset%0d got %b exp 0000", i, {Signal, valid, busy, done});
      end
    end
    // Reset cleared the stored pattern and restored full length.
    start = 1'b1;
    tick;
    start = 1'b0;
    cnt = 0; got_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid) begin
        checks++;
        if (Signal !== 1'b0) begin
          errors++; $display("FAIL post_reset_pattern_bit%0d got %b exp 0", cnt, Signal);
        end
        cnt++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick;
    end
    checks++;
    if (cnt !== 8 || got_done !== 1'b1) begin
      errors++; $display("FAIL post_reset_length got %0d/%b exp 8/1", cnt, got_done);
    end
    tick;
  endtask

`ifdef SERIAL_PRBS7_EN
  task automatic test_prbs;
    logic [6:0] m;
    m = 7'h7F;
    length = 4'd8; loop = 1'b1; prbs_sel = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; prbs_sel = 1'b0;
    for (int i = 0; i < 140; i++) begin
      checks++;
      if ({Signal, valid} !== {m[6], 1'b1}) begin
        errors++; $display("FAIL prbs_bit%0d got %b exp %b", i, {Signal, valid}, {m[6], 1'b1});
      end
      m = {m[5:0], m[6] ^ m[5]};
      tick;
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_one_shot;
    test_loop;
    test_stop;
    test_len_clamp;
    test_reset_mid;
`ifdef SERIAL_PRBS7_EN
    test_prbs;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
